cska_sub_seq: RTL and testbench



---
 rtl/cska_pkg.sv | 23 ++
 rtl/sub_blk4.sv | 32 +++
 rtl/cska_sub_seq.sv | 124 ++++++++++++
 tb/tb_cska_sub_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cska_pkg.sv
// Shared constants and types for the block-serial carry-skip subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cska_pkg;

    localparam int WIDTH = 32;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;
    localparam int SKW   = $clog2(NBLK + 1);
    localparam int IDXW  = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

endpackage

// File: rtl/sub_blk4.sv
// One BLK-bit subtract slice as A + ~B + ~bin, with carry-skip bypass on equal nibbles.
// Latency: purely combinational.
// Backpressure: none; the caller sequences blocks.
module sub_blk4
    import cska_pkg::*;
(
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           bin,
    output logic [BLK-1:0] d,
    output logic           bout,
    output logic           eq
);

    logic [BLK:0] c;

    always_comb begin
        c    = '0;
        d    = '0;
        c[0] = ~bin;
        for (int i = 0; i < BLK; i++) begin
            d[i]   = a[i] ^ ~b[i] ^ c[i];
            c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
        end
    end

    assign eq = &(~(a ^ b));

    // Equal nibbles propagate every bit, so the borrow passes straight through.
    assign bout = eq ? bin : ~c[BLK];

endmodule

// File: rtl/cska_sub_seq.sv
// Block-serial WIDTH-bit subtractor Diff = A - B - Bin with borrow, overflow, zero and skip count.
// Latency: result valid NBLK+1 edges after accept (one IDLE->RUN edge, then NBLK RUN edges).
// Backpressure: in_ready low from accept until DONE is released; DONE holds results while out_ready=0.
module cska_sub_seq
    import cska_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero,
    output logic [SKW-1:0]   skip_cnt
);

    state_t           state;
    state_t           state_nxt;
    op_t              op_q;
    logic [IDXW-1:0]  idx;
    logic             brw;
    logic [WIDTH-1:0] diff_q;
    logic             ovf_q;
    logic             zero_q;
    logic [SKW-1:0]   skip_q;

    logic [BLK-1:0]   a_blk;
    logic [BLK-1:0]   b_blk;
    logic [BLK-1:0]   d_blk;
    logic             bout_blk;
    logic             eq_blk;
    logic [WIDTH-1:0] diff_nxt;
    logic             last_blk;

    assign a_blk    = op_q.a[idx*BLK +: BLK];
    assign b_blk    = op_q.b[idx*BLK +: BLK];
    assign last_blk = (idx == IDXW'(NBLK - 1));

    sub_blk4 u_blk (
        .a    (a_blk),
        .b    (b_blk),
        .bin  (brw),
        .d    (d_blk),
        .bout (bout_blk),
        .eq   (eq_blk)
    );

    always_comb begin
        diff_nxt                   = diff_q;
        diff_nxt[idx*BLK +: BLK]   = d_blk;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_blk) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            idx    <= '0;
            brw    <= 1'b0;
            diff_q <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            skip_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q.a <= A;
                        op_q.b <= B;
                        brw    <= Bin;
                        idx    <= '0;
                        skip_q <= '0;
                    end
                end
                RUN: begin
                    diff_q <= diff_nxt;
                    brw    <= bout_blk;
                    skip_q <= skip_q + SKW'(eq_blk);
                    idx    <= idx + IDXW'(1);
                    // Flags are taken from the fully assembled difference on the final block.
                    if (last_blk) begin
                        ovf_q  <= (op_q.a[WIDTH-1] != op_q.b[WIDTH-1]) &&
                                  (diff_nxt[WIDTH-1] != op_q.a[WIDTH-1]);
                        zero_q <= (diff_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff     = diff_q;
    assign Bout     = brw;
    assign Ovf      = ovf_q;
    assign Zero     = zero_q;
    assign skip_cnt = skip_q;

endmodule

// File: tb/tb_cska_sub_seq.sv
// Directed bench for cska_sub_seq: hand-computed vectors, backpressure, reset abort, single-cycle release.
module tb_cska_sub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic [3:0]  skip_cnt;

    int tests_run;
    int tests_failed;
    int lat;

    cska_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .Bin       (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (diff),
        .Bout      (bout),
        .Ovf       (ovf),
        .Zero      (zero),
        .skip_cnt  (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request while idle; lat counts edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
        a_in     = a;
        b_in     = b;
        bin_in   = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (diff !== 32'h0) begin tests_failed++; $display("FAIL reset_diff got %h want 0", diff); end
        tests_run++; if ({bout, ovf, zero} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {bout, ovf, zero}); end
        tests_run++; if (skip_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_skip got %0d want 0", skip_cnt); end
    endtask

    task automatic test_basic();
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0);
        tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL basic_latency got %0d want 9", lat); end
        tests_run++; if (diff !== 32'h0000_0002) begin tests_failed++; $display("FAIL basic_diff got %h want 00000002", diff); end
        tests_run++; if ({bout, ovf, zero} !== 3'b000) begin tests_failed++; $display("FAIL basic_flags got %b want 000", {bout, ovf, zero}); end
        tests_run++; if (skip_cnt !== 4'd7) begin tests_failed++; $display("FAIL basic_skip got %0d want 7", skip_cnt); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
        release_done();
        tests_run++; if ({out_valid, in_ready} !== 2'b01) begin tests_failed++; $display("FAIL basic_release got ov/ir %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_borrow();
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        tests_run++; if (diff !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL borrow_diff got %h want ffffffff", diff); end
        tests_run++; if ({bout, ovf, zero} !== 3'b100) begin tests_failed++; $display("FAIL borrow_flags got %b want 100", {bout, ovf, zero}); end
        tests_run++; if (skip_cnt !== 4'd7) begin tests_failed++; $display("FAIL borrow_skip got %0d want 7", skip_cnt); end
        release_done();
    endtask

    task automatic test_overflow();
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        tests_run++; if (diff !== 32'h7FFF_FFFF) begin tests_failed++; $display("FAIL ovf_diff got %h want 7fffffff", diff); end
        tests_run++; if ({bout, ovf, zero} !== 3'b010) begin tests_failed++; $display("FAIL ovf_flags got %b want 010", {bout, ovf, zero}); end
        tests_run++; if (skip_cnt !== 4'd6) begin tests_failed++; $display("FAIL ovf_skip got %0d want 6", skip_cnt); end
        release_done();
    endtask

    task automatic test_equal();
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0);
        tests_run++; if (diff !== 32'h0) begin tests_failed++; $display("FAIL eq0_diff got %h want 00000000", diff); end
        tests_run++; if ({bout, ovf, zero} !== 3'b001) begin tests_failed++; $display("FAIL eq0_flags got %b want 001", {bout, ovf, zero}); end
        tests_run++; if (skip_cnt !== 4'd8) begin tests_failed++; $display("FAIL eq0_skip got %0d want 8", skip_cnt); end
        release_done();
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        tests_run++; if (diff !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL eq1_diff got %h want ffffffff", diff); end
        tests_run++; if ({bout, ovf, zero} !== 3'b100) begin tests_failed++; $display("FAIL eq1_flags got %b want 100", {bout, ovf, zero}); end
        tests_run++; if (skip_cnt !== 4'd8) begin tests_failed++; $display("FAIL eq1_skip got %0d want 8", skip_cnt); end
        release_done();
    endtask

    task automatic test_backpressure();
        int bad;
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0);
        a_in     = 32'h0000_0010;
        b_in     = 32'h0000_0001;
        bin_in   = 1'b0;
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'h2 || skip_cnt !== 4'd7 || bout !== 1'b0)
                bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if ({out_valid, in_ready} !== 2'b01) begin tests_failed++; $display("FAIL bp_release got ov/ir %b want 01", {out_valid, in_ready}); end
        tick();
        in_valid = 1'b0;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_accept got in_ready %b want 0", in_ready); end
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL bp_latency got %0d want 9", lat); end
        tests_run++; if (diff !== 32'h0000_000F || skip_cnt !== 4'd6) begin tests_failed++; $display("FAIL bp_result got %h/%0d want 0000000f/6", diff, skip_cnt); end
        release_done();
    endtask

    task automatic test_reset_mid_run();
        a_in     = 32'hFFFF_0000;
        b_in     = 32'h0000_FFFF;
        bin_in   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        tests_run++; if ({in_ready, out_valid} !== 2'b10) begin tests_failed++; $display("FAIL abort_hs got ir/ov %b want 10", {in_ready, out_valid}); end
        tests_run++; if ({bout, ovf, zero} !== 3'b000 || skip_cnt !== 4'd0 || diff !== 32'h0) begin tests_failed++; $display("FAIL abort_clear got flags %b skip %0d diff %h want 000/0/0", {bout, ovf, zero}, skip_cnt, diff); end
        run_op(32'h0000_0010, 32'h0000_0001, 1'b0);
        tests_run++; if (diff !== 32'h0000_000F) begin tests_failed++; $display("FAIL abort_fresh_diff got %h want 0000000f", diff); end
        tests_run++; if (skip_cnt !== 4'd6 || bout !== 1'b0) begin tests_failed++; $display("FAIL abort_fresh_skip got %0d/%b want 6/0", skip_cnt, bout); end
        release_done();
    endtask

    task automatic test_back_to_back();
        int hi;
        hi        = 0;
        out_ready = 1'b1;
        a_in      = 32'h0000_0100;
        b_in      = 32'h0000_0001;
        bin_in    = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                hi++;
                if (diff !== 32'h0000_00FF) begin tests_run++; tests_failed++; $display("FAIL b2b_diff got %h want 000000ff", diff); end
            end
        end
        out_ready = 1'b0;
        tests_run++; if (hi !== 1) begin tests_failed++; $display("FAIL b2b_valid_width got %0d cycles want 1", hi); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle got in_ready %b want 1", in_ready); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        lat          = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a_in         = '0;
        b_in         = '0;
        bin_in       = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_equal();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
